// File: rtl/idli_trace_buf_m.sv
// Retire-trace buffer: diffs each retired register state against a shadow copy
// and queues a compact record in a FIFO drained over a valid/ready port.
module idli_trace_buf_m #(
    parameter int NUM_GREGS = 8,
    parameter int GREG_W    = 16,
    parameter int NUM_PREGS = 4,
    parameter int DEPTH     = 8,
    parameter int SEQ_W     = 16
) (
    input  logic                          i_trc_gck,
    input  logic                          i_trc_rst,
    input  logic                          i_trc_en,
    input  logic                          i_trc_done,
    input  logic [NUM_GREGS*GREG_W-1:0]   i_trc_gregs,
    input  logic [NUM_PREGS-1:0]          i_trc_pregs,
    output logic                          o_trc_vld,
    input  logic                          i_trc_rdy,
    output logic [SEQ_W-1:0]              o_trc_seq,
    output logic [NUM_GREGS-1:0]          o_trc_mask,
    output logic [GREG_W-1:0]             o_trc_data,
    output logic [NUM_PREGS-1:0]          o_trc_pregs,
    output logic                          o_trc_ovf,
    output logic [SEQ_W-1:0]              o_trc_drop,
    output logic [$clog2(DEPTH):0]        o_trc_level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int REC_W = SEQ_W + NUM_GREGS + GREG_W + NUM_PREGS;

    logic [NUM_GREGS*GREG_W-1:0] shadow_q, shadow_d;
    logic [SEQ_W-1:0]            seq_q, seq_d;
    logic [SEQ_W-1:0]            drop_q, drop_d;
    logic                        ovf_q, ovf_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [REC_W-1:0]            mem_q [DEPTH];
    logic [REC_W-1:0]            mem_d [DEPTH];

    logic [NUM_GREGS-1:0]        rec_mask;
    logic [GREG_W-1:0]           rec_data;
    logic [REC_W-1:0]            head;
    logic                        empty, full;
    logic                        push_req, pop, push_ok, drop_now;

    // Descending scan so the lowest changed register is the last to win.
    always_comb begin
        rec_mask = '0;
        rec_data = '0;
        for (int i = NUM_GREGS - 1; i >= 0; i--) begin
            if (i_trc_gregs[i*GREG_W +: GREG_W] != shadow_q[i*GREG_W +: GREG_W]) begin
                rec_mask[i] = 1'b1;
                rec_data    = i_trc_gregs[i*GREG_W +: GREG_W];
            end
        end
    end

    // Handshake: a record transfers on any edge where o_trc_vld && i_trc_rdy;
    // o_trc_vld comes only from flops, and the head slot cannot change while
    // it is offered and not accepted.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push_req = i_trc_done && i_trc_en;
    assign pop      = !empty && i_trc_rdy;
    assign push_ok  = push_req && (!full || pop);
    assign drop_now = push_req && full && !pop;

    always_comb begin
        shadow_d = shadow_q;
        seq_d    = seq_q;
        if (i_trc_done) begin
            shadow_d = i_trc_gregs;
            seq_d    = seq_q + SEQ_W'(1);
        end

        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);

        ovf_d  = ovf_q || drop_now;
        drop_d = drop_q;
        if (drop_now && (drop_q != '1)) begin
            drop_d = drop_q + SEQ_W'(1);
        end

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = {seq_q, rec_mask, rec_data, i_trc_pregs};
        end
    end

    always_ff @(posedge i_trc_gck) begin
        if (i_trc_rst) begin
            shadow_q <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: slots are only visible once the pointers cover them.
    always_ff @(posedge i_trc_gck) begin
        mem_q <= mem_d;
    end

    assign head = mem_q[rd_ptr_q[AW-1:0]];
    assign {o_trc_seq, o_trc_mask, o_trc_data, o_trc_pregs} = head;
    assign o_trc_vld   = !empty;
    assign o_trc_level = wr_ptr_q - rd_ptr_q;
    assign o_trc_ovf   = ovf_q;
    assign o_trc_drop  = drop_q;

endmodule

// File: tb/tb_idli_trace_buf_m.sv
// Bench for idli_trace_buf_m: directed retire sequences checked every cycle
// against a queue-based record model, plus literal expectations per scenario.
module tb_idli_trace_buf_m;

    localparam int NG    = 8;
    localparam int GW    = 16;
    localparam int NP    = 4;
    localparam int DEPTH = 8;
    localparam int SW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              i_rst;
    logic              i_en;
    logic              i_done;
    logic [NG*GW-1:0]  i_gregs;
    logic [NP-1:0]     i_pregs;
    logic              i_rdy;
    logic              o_vld;
    logic [SW-1:0]     o_seq;
    logic [NG-1:0]     o_mask;
    logic [GW-1:0]     o_data;
    logic [NP-1:0]     o_pregs;
    logic              o_ovf;
    logic [SW-1:0]     o_drop;
    logic [LW-1:0]     o_level;

    idli_trace_buf_m #(
        .NUM_GREGS(NG), .GREG_W(GW), .NUM_PREGS(NP), .DEPTH(DEPTH), .SEQ_W(SW)
    ) dut (
        .i_trc_gck   (clk),
        .i_trc_rst   (i_rst),
        .i_trc_en    (i_en),
        .i_trc_done  (i_done),
        .i_trc_gregs (i_gregs),
        .i_trc_pregs (i_pregs),
        .o_trc_vld   (o_vld),
        .i_trc_rdy   (i_rdy),
        .o_trc_seq   (o_seq),
        .o_trc_mask  (o_mask),
        .o_trc_data  (o_data),
        .o_trc_pregs (o_pregs),
        .o_trc_ovf   (o_ovf),
        .o_trc_drop  (o_drop),
        .o_trc_level (o_level)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    // record layout: {seq[3:0], mask[7:0], data[15:0], pregs[3:0]}
    logic [31:0]  exp_q[$];
    logic [31:0]  got_q[$];
    logic [GW-1:0] m_shadow [NG];
    int           m_seq;
    int           m_drop;
    logic         m_ovf;
    logic         m_live;
    int           n_checks;
    int           n_errs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    function automatic logic [NG*GW-1:0] set_reg(input logic [NG*GW-1:0] g, input int idx,
                                                 input logic [GW-1:0] v);
        logic [NG*GW-1:0] r;
        r = g;
        r[idx*GW +: GW] = v;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    always @(posedge clk) begin
        logic          pop_now;
        logic [NG-1:0] mask;
        logic [GW-1:0] data;
        logic [GW-1:0] cur;
        logic          found;
        logic          push_now;
        if (i_rst) begin
            exp_q.delete();
            for (int i = 0; i < NG; i++) m_shadow[i] = '0;
            m_seq  = 0;
            m_drop = 0;
            m_ovf  = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            pop_now  = (exp_q.size() != 0) && i_rdy;
            push_now = 1'b0;
            mask     = '0;
            data     = '0;
            found    = 1'b0;
            for (int i = 0; i < NG; i++) begin
                cur = i_gregs[i*GW +: GW];
                if (cur != m_shadow[i]) begin
                    mask[i] = 1'b1;
                    if (!found) begin
                        data  = cur;
                        found = 1'b1;
                    end
                end
            end
            if (i_done && i_en) begin
                if (exp_q.size() < DEPTH || pop_now) push_now = 1'b1;
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < (1 << SW) - 1) m_drop++;
                end
            end
            if (pop_now) void'(exp_q.pop_front());
            if (push_now) exp_q.push_back({4'(m_seq), mask, data, i_pregs});
            if (i_done) begin
                for (int i = 0; i < NG; i++) m_shadow[i] = i_gregs[i*GW +: GW];
                m_seq = (m_seq + 1) % (1 << SW);
            end
        end
    end

    // ---------------- compare process (opposite edge) ----------------
    always @(negedge clk) begin
        if (m_live) begin
            check("vld",   32'(o_vld),   32'(exp_q.size() != 0));
            check("level", 32'(o_level), 32'(exp_q.size()));
            check("ovf",   32'(o_ovf),   32'(m_ovf));
            check("drop",  32'(o_drop),  32'(m_drop));
            if (exp_q.size() != 0)
                check("head", {o_seq, o_mask, o_data, o_pregs}, exp_q[0]);
            if (o_vld && i_rdy && !i_rst)
                got_q.push_back({o_seq, o_mask, o_data, o_pregs});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic done, input logic en, input logic rdy,
                         input logic [NG*GW-1:0] g, input logic [NP-1:0] p);
        i_done  = done;
        i_en    = en;
        i_rdy   = rdy;
        i_gregs = g;
        i_pregs = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, rdy, i_gregs, i_pregs);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        idle(1, 1'b0);
        i_rst = 1'b0;
    endtask

    function automatic logic [NG*GW-1:0] rand_regs();
        logic [NG*GW-1:0] g;
        for (int i = 0; i < NG; i++) g[i*GW +: GW] = GW'($urandom_range(0, 3));
        return g;
    endfunction

    // ---------------- directed stimulus ----------------
    initial begin
        logic [NG*GW-1:0] g;
        n_checks = 0;
        n_errs   = 0;
        m_live   = 1'b0;
        i_rst    = 1'b1;
        i_en     = 1'b0;
        i_done   = 1'b0;
        i_rdy    = 1'b0;
        i_gregs  = '0;
        i_pregs  = '0;
        idle(2, 1'b0);
        i_rst = 1'b0;

        check("rst_vld",   32'(o_vld),   32'd0);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_ovf",   32'(o_ovf),   32'd0);
        check("rst_drop",  32'(o_drop),  32'd0);

        // Basic diff records; first one also pins the no-bypass latency.
        got_q.delete();
        g = set_reg('0, 2, 16'h1234);
        i_done = 1'b1; i_en = 1'b1; i_rdy = 1'b1; i_gregs = g; i_pregs = 4'h1;
        #1;
        check("no_bypass", 32'(o_vld), 32'd0);
        @(posedge clk);
        #1;
        check("push_lat", 32'(o_vld), 32'd1);
        drive(1'b1, 1'b1, 1'b1, g, 4'h2);
        g = set_reg(g, 0, 16'hBEEF);
        g = set_reg(g, 5, 16'h0001);
        drive(1'b1, 1'b1, 1'b1, g, 4'h3);
        idle(3, 1'b1);
        check("s1_count", 32'(got_q.size()), 32'd3);
        check("s1_rec0", got_at(0), {4'h0, 8'h04, 16'h1234, 4'h1});
        check("s1_rec1", got_at(1), {4'h1, 8'h00, 16'h0000, 4'h2});
        check("s1_rec2", got_at(2), {4'h2, 8'h21, 16'hBEEF, 4'h3});

        // Overflow: DEPTH+3 pushes with no consumer.
        do_reset();
        got_q.delete();
        for (int k = 0; k < DEPTH + 3; k++) drive(1'b1, 1'b1, 1'b0, rand_regs(), 4'(k));
        check("ovf_level", 32'(o_level), 32'(DEPTH));
        check("ovf_flag",  32'(o_ovf),   32'd1);
        check("ovf_drop",  32'(o_drop),  32'd3);
        // Push and pop together while full.
        drive(1'b1, 1'b1, 1'b1, rand_regs(), 4'hA);
        check("pp_level", 32'(o_level), 32'(DEPTH));
        check("pp_drop",  32'(o_drop),  32'd3);
        idle(DEPTH + 2, 1'b1);
        check("drain_vld",   32'(o_vld), 32'd0);
        check("drain_count", 32'(got_q.size()), 32'(DEPTH + 1));
        for (int k = 0; k < DEPTH; k++) check("drain_seq", 32'(got_at(k)[31:28]), 32'(k));
        check("pp_last_seq", 32'(got_at(DEPTH)[31:28]), 32'd11);

        // Drop counter saturation at all-ones.
        for (int k = 0; k < DEPTH + 14; k++) drive(1'b1, 1'b1, 1'b0, rand_regs(), 4'h0);
        check("sat_drop",  32'(o_drop),  32'd15);
        check("sat_level", 32'(o_level), 32'(DEPTH));
        do_reset();
        check("clr_ovf",  32'(o_ovf),  32'd0);
        check("clr_drop", 32'(o_drop), 32'd0);
        check("clr_vld",  32'(o_vld),  32'd0);

        // Disabled retires still advance seq and shadow.
        got_q.delete();
        g = set_reg('0, 1, 16'h0011);
        drive(1'b1, 1'b0, 1'b1, g, 4'h5);
        g = set_reg(g, 3, 16'h0033);
        drive(1'b1, 1'b0, 1'b1, g, 4'h6);
        g = set_reg(g, 7, 16'h7777);
        drive(1'b1, 1'b1, 1'b1, g, 4'h7);
        idle(3, 1'b1);
        check("en_count", 32'(got_q.size()), 32'd1);
        check("en_rec",   got_at(0), {4'h2, 8'h80, 16'h7777, 4'h7});

        // Sequence wrap with back-to-back retires.
        do_reset();
        got_q.delete();
        for (int k = 0; k < 17; k++) drive(1'b1, 1'b1, 1'b1, rand_regs(), 4'(k));
        idle(3, 1'b1);
        check("wrap_count", 32'(got_q.size()), 32'd17);
        for (int k = 0; k < 16; k++) check("wrap_seq", 32'(got_at(k)[31:28]), 32'(k));
        check("wrap_seq16", 32'(got_at(16)[31:28]), 32'd0);
        check("wrap_drop",  32'(o_drop), 32'd0);

        // Reset with records queued and a push in flight.
        do_reset();
        g = set_reg('0, 4, 16'h4444);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 1'b0, g, 4'h9);
        check("q5_level", 32'(o_level), 32'd5);
        i_rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, g, 4'h9);
        i_rst = 1'b0;
        check("flush_vld",   32'(o_vld),   32'd0);
        check("flush_level", 32'(o_level), 32'd0);
        check("flush_ovf",   32'(o_ovf),   32'd0);
        check("flush_drop",  32'(o_drop),  32'd0);
        got_q.delete();
        drive(1'b1, 1'b1, 1'b1, g, 4'hC);
        idle(3, 1'b1);
        check("flush_count", 32'(got_q.size()), 32'd1);
        check("flush_rec",   got_at(0), {4'h0, 8'h10, 16'h4444, 4'hC});

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
